fetch_unit: RTL and testbench

Instruction-fetch front end that sits directly upstream of the IF/RF pipeline register. It owns the fetch PC and issues requests to a variable-latency instruction memory. Returned words go into a small in-order queue, which feeds the decode side through a valid/ready handshake. An accelerated-branch redirect from the RF stage discards every instruction not yet accepted downstream and restarts fetch at the target.

---
 rtl/fetch_unit_pkg.sv | 15 +
 rtl/fetch_queue.sv | 53 +++++
 rtl/fetch_unit.sv | 113 +++++++++++
 tb/tb_fetch_unit.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared CPU front-end definitions.
// Widths, fetch FSM encoding and instruction stride.
package fetch_unit_pkg;

  localparam int CPU_ADDR_W = 64;
  localparam int CPU_INSTR_W = 32;
  localparam int unsigned FETCH_STRIDE = 4;

  typedef logic [1:0] fstate_t;

  localparam fstate_t S_REQ = 2'd0;
  localparam fstate_t S_WAIT = 2'd1;
  localparam fstate_t S_DROP = 2'd2;

endpackage

// File: rtl/fetch_queue.sv
// In-order circular instruction queue.
// Flush wins over push/pop; storage clears on reset.
module fetch_queue #(
  parameter int W = 96,
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  logic [W-1:0]            wdata,
  output logic [$clog2(DEPTH):0]  count,
  output logic [W-1:0]            head_data
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[tail] <= wdata;
        tail      <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  assign head_data = mem[head];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, single-outstanding imem
// requests, response queue and branch-redirect flush.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = CPU_ADDR_W,
  parameter int                INSTR_W  = CPU_INSTR_W,
  parameter int                QDEPTH   = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc
);

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int EW = INSTR_W + ADDR_W;
  localparam logic [CW:0] QCAP = (CW+1)'(QDEPTH);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(FETCH_STRIDE);
  localparam logic [ADDR_W-1:0] ALIGN = ~(STEP - ADDR_W'(1));

  fstate_t           state;
  fstate_t           state_n;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] req_pc;
  logic [ADDR_W-1:0] target;
  logic [CW-1:0]     count;
  logic [CW:0]       occ;
  logic [EW-1:0]     head;
  logic              waiting;
  logic              resp;
  logic              pop;
  logic              push;
  logic              grant;

  assign waiting = (state == S_WAIT);
  assign resp    = imem_rvalid & (state != S_REQ);
  assign target  = redirect_pc & ALIGN;

  assign out_valid = (count != '0) & ~redirect;
  assign pop       = out_valid & out_ready;

  // Slots in use once the pending response lands, net of this pop
  assign occ = {1'b0, count}
             + {{CW{1'b0}}, waiting}
             - {{CW{1'b0}}, pop};

  assign imem_req = reset & ~redirect
                  & ((state == S_REQ) | (waiting & imem_rvalid))
                  & (occ < QCAP);
  assign imem_addr = fetch_pc;
  assign grant     = imem_req & imem_gnt;
  assign push      = waiting & imem_rvalid & ~redirect;

  always_comb begin
    state_n = state;
    if (redirect) begin
      if (waiting) begin
        state_n = imem_rvalid ? S_REQ : S_DROP;
      end else if (resp) begin
        state_n = S_REQ;
      end
    end else if (grant) begin
      state_n = S_WAIT;
    end else if (resp) begin
      state_n = S_REQ;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_REQ;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
    end else begin
      state <= state_n;
      if (redirect) begin
        fetch_pc <= target;
      end else if (grant) begin
        fetch_pc <= fetch_pc + STEP;
        req_pc   <= fetch_pc;
      end
    end
  end

  fetch_queue #(
    .W     (EW),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .flush     (redirect),
    .wdata     ({imem_rdata, req_pc}),
    .count     (count),
    .head_data (head)
  );

  assign out_instr = head[EW-1 -: INSTR_W];
  assign out_pc    = head[ADDR_W-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized bench for fetch_unit with a
// variable-latency memory and an in-order PC stream model.
module tb_fetch_unit;

  localparam int AW = 64;
  localparam int IW = 32;
  localparam logic [AW-1:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          gnt;
  logic          rdy;
  logic          redir;
  logic [AW-1:0] redir_pc;
  logic          req;
  logic [AW-1:0] addr;
  logic          rvalid;
  logic [IW-1:0] rdata;
  logic          ov;
  logic [IW-1:0] oi;
  logic [AW-1:0] opc;

  logic          req_w;
  logic [AW-1:0] addr_w;
  logic          rvalid_w;
  logic [IW-1:0] rdata_w;
  logic          ov_w;
  logic [IW-1:0] oi_w;
  logic [AW-1:0] opc_w;

  int            cur_lat;
  logic          pend;
  int            cnt;
  logic [AW-1:0] paddr;

  int            checks = 0;
  int            passes = 0;
  logic          mon_en = 1'b0;
  logic [AW-1:0] exp_pc;
  int            npop;

  function automatic logic [IW-1:0] mword(input logic [AW-1:0] a);
    logic [IW-1:0] x;
    x = a[IW-1:0] ^ a[AW-1:IW];
    return (x * 32'h9E37_79B1) + 32'h0BAD_F00D;
  endfunction

  task automatic chk(input string tag,
                     input logic [AW-1:0] obs,
                     input logic [AW-1:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  fetch_unit #(
    .ADDR_W   (AW),
    .INSTR_W  (IW),
    .QDEPTH   (2),
    .RESET_PC ('0)
  ) dut (
    .clk         (clk),
    .reset       (rst_n),
    .imem_req    (req),
    .imem_addr   (addr),
    .imem_gnt    (gnt),
    .imem_rvalid (rvalid),
    .imem_rdata  (rdata),
    .redirect    (redir),
    .redirect_pc (redir_pc),
    .out_valid   (ov),
    .out_ready   (rdy),
    .out_instr   (oi),
    .out_pc      (opc)
  );

  fetch_unit #(
    .ADDR_W   (AW),
    .INSTR_W  (IW),
    .QDEPTH   (2),
    .RESET_PC (WRAP_PC)
  ) dut_w (
    .clk         (clk),
    .reset       (rst_n),
    .imem_req    (req_w),
    .imem_addr   (addr_w),
    .imem_gnt    (1'b1),
    .imem_rvalid (rvalid_w),
    .imem_rdata  (rdata_w),
    .redirect    (1'b0),
    .redirect_pc ('0),
    .out_valid   (ov_w),
    .out_ready   (1'b1),
    .out_instr   (oi_w),
    .out_pc      (opc_w)
  );

  // Memory: latency cur_lat captured at grant, one response per grant
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      pend   <= 1'b0;
      cnt    <= 0;
      paddr  <= '0;
    end else begin
      rvalid <= 1'b0;
      if (pend) begin
        if (cnt <= 1) begin
          rvalid <= 1'b1;
          rdata  <= mword(paddr);
          pend   <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end
      if (req && gnt) begin
        if (cur_lat <= 1) begin
          rvalid <= 1'b1;
          rdata  <= mword(addr);
        end else begin
          pend  <= 1'b1;
          cnt   <= cur_lat - 1;
          paddr <= addr;
        end
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_w <= 1'b0;
      rdata_w  <= '0;
    end else begin
      rvalid_w <= req_w;
      rdata_w  <= mword(addr_w);
    end
  end

  // Stream model: accepted PCs run +4 from the last redirect target
  always @(negedge clk) begin
    if (mon_en) begin
      chk("req_while_busy", {63'b0, req & pend}, '0);
      if (redir) begin
        exp_pc <= redir_pc & ~64'd3;
      end else if (ov && rdy) begin
        chk("rnd_pc", opc, exp_pc);
        chk("rnd_instr", {32'b0, oi}, {32'b0, mword(opc)});
        exp_pc <= exp_pc + 64'd4;
        npop   <= npop + 1;
      end
    end
  end

  initial begin
    gnt      = 1'b1;
    rdy      = 1'b1;
    redir    = 1'b0;
    redir_pc = '0;
    cur_lat  = 1;
    npop     = 0;
    exp_pc   = '0;

    repeat (2) tick();
    chk("rst_req", {63'b0, req}, 0);
    chk("rst_addr", addr, 0);
    chk("rst_ov", {63'b0, ov}, 0);
    chk("rst_instr", {32'b0, oi}, 0);
    chk("rst_pc", opc, 0);
    chk("rst_addr_w", addr_w, WRAP_PC);

    // Streaming fill with k=1, out_ready high
    rst_n = 1'b1;
    #1;
    chk("rel_req", {63'b0, req}, 1);
    chk("g0_ov", {63'b0, ov}, 0);
    tick();
    chk("g1_ov", {63'b0, ov}, 0);
    tick();
    chk("g2_ov", {63'b0, ov}, 1);
    chk("g2_pc", opc, 64'd0);
    chk("g2_instr", {32'b0, oi}, {32'b0, mword(64'd0)});
    chk("w_pc0", opc_w, WRAP_PC);
    chk("w_instr0", {32'b0, oi_w}, {32'b0, mword(WRAP_PC)});
    tick();
    chk("g3_pc", opc, 64'd4);
    chk("w_pc1", opc_w, 64'd0);
    chk("w_ov1", {63'b0, ov_w}, 1);
    tick();
    chk("g4_pc", opc, 64'd8);
    tick();
    chk("g5_pc", opc, 64'd12);
    chk("g5_ov", {63'b0, ov}, 1);

    // Backpressure: two entries held, request stalls
    rst_n = 1'b0;
    rdy = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("bp_req0", {63'b0, req}, 1);
    repeat (3) tick();
    chk("bp_req3", {63'b0, req}, 0);
    repeat (2) tick();
    chk("bp_req5", {63'b0, req}, 0);
    chk("bp_ov5", {63'b0, ov}, 1);
    chk("bp_pc5", opc, 64'd0);
    tick();
    rdy = 1'b1;
    #1;
    chk("bp_req_pop", {63'b0, req}, 1);
    chk("bp_addr", addr, 64'd8);
    chk("bp_pc6", opc, 64'd0);
    tick();
    chk("bp_pc7", opc, 64'd4);
    chk("bp_ov7", {63'b0, ov}, 1);
    tick();
    chk("bp_pc8", opc, 64'd8);

    // Redirect while a response is outstanding
    rst_n = 1'b0;
    rdy = 1'b0;
    cur_lat = 2;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("rd_pre_ov", {63'b0, ov}, 1);
    chk("rd_pre_pc", opc, 64'd0);
    redir = 1'b1;
    redir_pc = 64'h103;
    #1;
    chk("rd_ov", {63'b0, ov}, 0);
    chk("rd_req", {63'b0, req}, 0);
    tick();
    redir = 1'b0;
    #1;
    chk("drop_req", {63'b0, req}, 0);
    chk("drop_ov", {63'b0, ov}, 0);
    chk("drop_addr", addr, 64'h100);
    tick();
    chk("tgt_req", {63'b0, req}, 1);
    chk("tgt_addr", addr, 64'h100);
    tick();
    chk("tgt_ov6", {63'b0, ov}, 0);
    tick();
    chk("tgt_ov7", {63'b0, ov}, 0);
    tick();
    chk("tgt_ov8", {63'b0, ov}, 1);
    chk("tgt_pc", opc, 64'h100);
    chk("tgt_instr", {32'b0, oi}, {32'b0, mword(64'h100)});

    // Redirect coinciding with a response
    rdy = 1'b1;
    cur_lat = 1;
    repeat (2) tick();
    chk("rv_pre", {63'b0, rvalid}, 1);
    redir = 1'b1;
    redir_pc = 64'h200;
    tick();
    redir = 1'b0;
    #1;
    chk("rv_req", {63'b0, req}, 1);
    chk("rv_addr", addr, 64'h200);
    chk("rv_ov1", {63'b0, ov}, 0);
    tick();
    chk("rv_ov2", {63'b0, ov}, 0);
    tick();
    chk("rv_ov3", {63'b0, ov}, 1);
    chk("rv_pc", opc, 64'h200);

    // Reset pulse during WAIT with an entry queued
    rst_n = 1'b0;
    rdy = 1'b0;
    cur_lat = 2;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("mr_pre_ov", {63'b0, ov}, 1);
    rst_n = 1'b0;
    #1;
    chk("mr_ov", {63'b0, ov}, 0);
    chk("mr_addr", addr, 64'd0);
    chk("mr_req", {63'b0, req}, 0);
    chk("mr_pc", opc, 64'd0);
    cur_lat = 1;
    rdy = 1'b1;
    tick();
    rst_n = 1'b1;
    #1;
    chk("mr_rel_req", {63'b0, req}, 1);
    chk("mr_rel_addr", addr, 64'd0);
    repeat (2) tick();
    chk("mr_pc0", opc, 64'd0);
    chk("mr_ov0", {63'b0, ov}, 1);
    tick();
    chk("mr_pc1", opc, 64'd4);

    // Randomized traffic against the stream model
    mon_en = 1'b1;
    redir = 1'b1;
    redir_pc = {32'h0, $urandom};
    tick();
    redir = 1'b0;
    repeat (1500) begin
      tick();
      gnt = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      cur_lat = $urandom_range(1, 3);
      if ($urandom_range(0, 40) == 0) begin
        redir = 1'b1;
        redir_pc = {$urandom, $urandom};
      end else begin
        redir = 1'b0;
      end
    end
    redir = 1'b0;
    tick();
    mon_en = 1'b0;
    chk("rnd_progress", {63'b0, npop > 200}, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
